// File: rtl/wave_gen.sv
// wave_gen: bank of independent waveform generators (triangle, sawtooth,
// square, hold) behind a simple valid/ready register bus. Each channel has
// CTRL/DIV/VALUE registers; out carries every channel's current sample.
module wave_gen #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid,
  output logic                      ready,
  input  logic [3:0]                wstrb,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       sync
);

  typedef enum logic [1:0] {
    MODE_TRI  = 2'd0,
    MODE_SAW  = 2'd1,
    MODE_SQR  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_DIV   = 2'd1,
    REG_VALUE = 2'd2,
    REG_RSVD  = 2'd3
  } reg_e;

  localparam logic [WIDTH-1:0] MAX = '1;

  // Per-channel state
  logic [CHANNELS-1:0]            en_q;
  logic [CHANNELS-1:0][1:0]       mode_q;
  logic [CHANNELS-1:0][31:0]      div_q;
  logic [CHANNELS-1:0][31:0]      cnt_q;
  logic [CHANNELS-1:0][WIDTH-1:0] sample_q;
  logic [CHANNELS-1:0]            down_q;

  // Step results, used only when a channel's counter reaches DIV
  logic [CHANNELS-1:0][WIDTH-1:0] nxt_sample;
  logic [CHANNELS-1:0]            nxt_down;
  logic [CHANNELS-1:0]            nxt_sync;

  // Bus decode
  logic                accept;
  reg_e                reg_sel;
  logic [2:0]          ch_sel;
  logic [31:0]         rd_value;
  logic [CHANNELS-1:0] wr_ctrl;
  logic [CHANNELS-1:0] wr_div;

  // Only addr[6:2] selects anything; the rest of the address is don't-care.
  logic unused_addr;
  assign unused_addr = ^{addr[31:7], addr[1:0]};

  // A request is taken only while ready is low, which forces a gap cycle.
  assign accept  = valid && !ready;
  assign reg_sel = reg_e'(addr[3:2]);
  assign ch_sel  = addr[6:4];
  assign out     = sample_q;

  // Merge the strobed bytes of wdata into an existing register value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // Read mux and write decode; unmatched channel fields read 0 and write nothing.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    rd_value = '0;
    wr_ctrl  = '0;
    wr_div   = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (ch_sel == 3'(n)) begin
        case (reg_sel)
          REG_CTRL:  rd_value = {29'd0, mode_q[n], en_q[n]};
          REG_DIV:   rd_value = div_q[n];
          REG_VALUE: rd_value = 32'(sample_q[n]);
          default:   rd_value = '0;
        endcase
        wr_ctrl[n] = accept && (wstrb != 4'h0) && (reg_sel == REG_CTRL);
        wr_div[n]  = accept && (wstrb != 4'h0) && (reg_sel == REG_DIV);
      end
    end
  end

  // Next sample, direction and period marker for a step in each mode.
  always_comb begin
    nxt_sample = sample_q;
    nxt_down   = down_q;
    nxt_sync   = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      case (mode_e'(mode_q[n]))
        MODE_TRI: begin
          if (sample_q[n] == MAX) begin
            nxt_sample[n] = MAX - WIDTH'(1);
            nxt_down[n]   = 1'b1;
          end else if (sample_q[n] == '0) begin
            nxt_sample[n] = WIDTH'(1);
            nxt_down[n]   = 1'b0;
            nxt_sync[n]   = 1'b1;
          end else if (down_q[n]) begin
            nxt_sample[n] = sample_q[n] - WIDTH'(1);
          end else begin
            nxt_sample[n] = sample_q[n] + WIDTH'(1);
          end
        end
        MODE_SAW: begin
          nxt_sample[n] = sample_q[n] + WIDTH'(1);
          nxt_sync[n]   = (sample_q[n] == MAX);
        end
        MODE_SQR: begin
          nxt_sample[n] = (sample_q[n] == '0) ? MAX : '0;
          nxt_sync[n]   = (sample_q[n] == '0);
        end
        default: begin
          nxt_sample[n] = sample_q[n];
        end
      endcase
    end
  end

  // Bus handshake, register writes and per-channel waveform sequencing.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the register file is built from flops, not RAM, so every entry can be cleared here like any other state.
      ready    <= 1'b0;
      rdata    <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      down_q   <= '0;
      sync     <= '0;
    end else begin
      ready <= accept;
      if (accept) begin
        rdata <= rd_value;
      end
      for (int n = 0; n < CHANNELS; n++) begin
        if (wr_ctrl[n] && wstrb[0]) begin
          en_q[n]   <= wdata[0];
          mode_q[n] <= wdata[2:1];
        end
        if (wr_div[n]) begin
          div_q[n] <= merge_bytes(div_q[n], wdata, wstrb);
        end

        if (wr_ctrl[n] || wr_div[n] || !en_q[n] || (div_q[n] == '0)) begin
          // Configuration change or idle channel: restart from the cleared state.
          cnt_q[n]    <= '0;
          sample_q[n] <= '0;
          down_q[n]   <= 1'b0;
          sync[n]     <= 1'b0;
        end else if (cnt_q[n] == div_q[n]) begin
          // counter never exceeds DIV, so DIV=FFFFFFFF cannot overflow it
          cnt_q[n]    <= '0;
          sample_q[n] <= nxt_sample[n];
          down_q[n]   <= nxt_down[n];
          sync[n]     <= nxt_sync[n];
        end else begin
          cnt_q[n] <= cnt_q[n] + 32'd1;
          sync[n]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed scenarios plus random bus traffic against a
// closed-form model (sample derived from elapsed running cycles).
module tb_wave_gen;

  localparam int CH = 2;
  localparam int W  = 8;
  localparam longint MAXV = (longint'(1) << W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid;
  logic            ready;
  logic [3:0]      wstrb;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [CH*W-1:0] out;
  logic [CH-1:0]   sync;

  int n_vec = 0;
  int n_err = 0;
  logic checking = 1'b0;

  // Model state: configuration plus cycles spent running since last clear.
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_en   [CH];
  logic [1:0]  m_mode [CH];
  logic [31:0] m_div  [CH];
  longint      m_t    [CH];

  wave_gen #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .ready (ready),
    .wstrb (wstrb),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .out   (out),
    .sync  (sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample after t running cycles: one step every DIV+1 cycles.
  function automatic logic [W-1:0] exp_sample(input logic [1:0] mode, input logic [31:0] div,
                                               input longint t);
    longint k, p;
    k = t / (longint'(div) + 1);
    case (mode)
      2'd0: begin
        p = k % (2 * MAXV);
        return W'((p <= MAXV) ? p : (2 * MAXV - p));
      end
      2'd1:    return W'(k % (MAXV + 1));
      2'd2:    return ((k % 2) == 1) ? W'(MAXV) : '0;
      default: return '0;
    endcase
  endfunction

  function automatic logic exp_sync(input logic [1:0] mode, input logic [31:0] div,
                                    input longint t);
    longint k;
    if (t == 0 || (t % (longint'(div) + 1)) != 0) return 1'b0;
    k = t / (longint'(div) + 1);
    case (mode)
      2'd0:    return (k % (2 * MAXV)) == 1;
      2'd1:    return (k % (MAXV + 1)) == 0;
      2'd2:    return (k % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int ch;
    ch = int'(a[6:4]);
    if (ch >= CH) return 32'd0;
    case (a[3:2])
      2'd0:    return {29'd0, m_mode[ch], m_en[ch]};
      2'd1:    return m_div[ch];
      2'd2:    return 32'(exp_sample(m_mode[ch], m_div[ch], m_t[ch]));
      default: return 32'd0;
    endcase
  endfunction

  // Reference model, advanced on every rising edge from the applied inputs.
  always @(posedge clk) begin : model
    logic        acc;
    logic [31:0] rd;
    int          ch;
    if (reset) begin
      m_ready <= 1'b0;
      m_rdata <= '0;
      for (int n = 0; n < CH; n++) begin
        m_en[n]   <= 1'b0;
        m_mode[n] <= '0;
        m_div[n]  <= '0;
        m_t[n]    <= 0;
      end
    end else begin
      acc = valid && !m_ready;
      rd  = model_read(addr);
      ch  = int'(addr[6:4]);
      m_ready <= acc;
      if (acc) m_rdata <= rd;
      for (int n = 0; n < CH; n++) begin
        if (acc && wstrb != 4'h0 && n == ch && addr[3:2] < 2'd2) begin
          if (addr[3:2] == 2'd0) begin
            if (wstrb[0]) begin
              m_en[n]   <= wdata[0];
              m_mode[n] <= wdata[2:1];
            end
          end else begin
            for (int b = 0; b < 4; b++)
              if (wstrb[b]) m_div[n][8*b +: 8] <= wdata[8*b +: 8];
          end
          m_t[n] <= 0;
        end else if (!m_en[n] || m_div[n] == 32'd0) begin
          m_t[n] <= 0;
        end else begin
          m_t[n] <= m_t[n] + 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      check("ready", 32'(ready), 32'(m_ready));
      check("rdata", rdata, m_rdata);
      for (int n = 0; n < CH; n++) begin
        check($sformatf("out%0d", n), 32'(out[n*W +: W]),
              32'(exp_sample(m_mode[n], m_div[n], m_t[n])));
        check($sformatf("sync%0d", n), 32'(sync[n]),
              32'(exp_sync(m_mode[n], m_div[n], m_t[n])));
      end
    end
  end

  task automatic bus(input logic [3:0] strb, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    @(negedge clk);
    valid = 1'b1; wstrb = strb; addr = a; wdata = d;
    @(negedge clk);
    valid = 1'b0; wstrb = 4'h0;
    rd = rdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic        pat [4];

    // Reset with a write pending: it must not be taken.
    reset = 1'b1; valid = 1'b1; wstrb = 4'hF; addr = 32'h0; wdata = 32'h1;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b0; valid = 1'b0; wstrb = 4'h0;
    bus(4'h0, 32'h0, 32'h0, rd);
    check("ctrl0_after_rst", rd, 32'd0);

    // Enabled with DIV=0: channel stays idle.
    bus(4'hF, 32'h00, 32'h1, rd);
    bus(4'hF, 32'h04, 32'h0, rd);
    repeat (20) @(negedge clk);
    check("div0_idle_out", 32'(out[0 +: W]), 32'd0);

    // Triangle, DIV=1: one step every 2 cycles.
    bus(4'hF, 32'h04, 32'h1, rd);
    bus(4'hF, 32'h00, 32'h1, rd);
    repeat (2) @(negedge clk);
    check("tri_first", 32'(out[0 +: W]), 32'd1);
    check("tri_first_sync", 32'(sync[0]), 32'd1);
    repeat (508) @(negedge clk);
    check("tri_peak", 32'(out[0 +: W]), 32'd255);
    repeat (2) @(negedge clk);
    check("tri_turn", 32'(out[0 +: W]), 32'd254);
    repeat (508) @(negedge clk);
    check("tri_floor", 32'(out[0 +: W]), 32'd0);
    repeat (2) @(negedge clk);
    check("tri_again", 32'(out[0 +: W]), 32'd1);

    // Channel 1 sawtooth; idle while DIV=0, then counts and wraps.
    bus(4'hF, 32'h10, 32'h3, rd);
    repeat (10) @(negedge clk);
    check("saw_div0", 32'(out[W +: W]), 32'd0);
    bus(4'hF, 32'h14, 32'h1, rd);
    repeat (510) @(negedge clk);
    check("saw_top", 32'(out[W +: W]), 32'd255);
    repeat (2) @(negedge clk);
    check("saw_wrap", 32'(out[W +: W]), 32'd0);
    check("saw_wrap_sync", 32'(sync[1]), 32'd1);

    // Square, DIV=3; a DIV write mid-run forces 0.
    bus(4'hF, 32'h04, 32'h3, rd);
    bus(4'hF, 32'h00, 32'h5, rd);
    repeat (4) @(negedge clk);
    check("sqr_high", 32'(out[0 +: W]), 32'hFF);
    check("sqr_sync", 32'(sync[0]), 32'd1);
    bus(4'hF, 32'h04, 32'h3, rd);
    check("sqr_div_clear", 32'(out[0 +: W]), 32'd0);

    // Back-to-back reads of VALUE: ready alternates.
    @(negedge clk);
    valid = 1'b1; wstrb = 4'h0; addr = 32'h18;
    for (int i = 0; i < 4; i++) begin
      pat[i] = ready;
      @(negedge clk);
    end
    valid = 1'b0;
    check("ready_pat", {28'd0, pat[0], pat[1], pat[2], pat[3]}, 32'h5);

    // Unimplemented channel reads 0 and ignores writes.
    bus(4'hF, 32'h54, 32'h1234, rd);
    bus(4'h0, 32'h54, 32'h0, rd);
    check("ch5_div", rd, 32'd0);

    // Byte-strobed DIV write from reset, then reset mid-transaction.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    bus(4'h2, 32'h04, 32'h0000AB00, rd);
    bus(4'h0, 32'h04, 32'h0, rd);
    check("div_strobe", rd, 32'h0000AB00);
    bus(4'hF, 32'h14, 32'h2, rd);
    bus(4'hF, 32'h10, 32'h5, rd);
    bus(4'hF, 32'h00, 32'h1, rd);
    repeat (20) @(negedge clk);
    @(negedge clk);
    valid = 1'b1; wstrb = 4'hF; addr = 32'h14; wdata = 32'h7; reset = 1'b1;
    @(negedge clk);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_sync", 32'(sync), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    reset = 1'b0; valid = 1'b0; wstrb = 4'h0;
    bus(4'h0, 32'h14, 32'h0, rd);
    check("midrst_div1", rd, 32'd0);

    // Huge DIV: running but never steps within the window.
    bus(4'hF, 32'h04, 32'hFFFF_FFFF, rd);
    bus(4'hF, 32'h00, 32'h3, rd);
    repeat (50) @(negedge clk);
    check("bigdiv_out", 32'(out[0 +: W]), 32'd0);

    // Random bus traffic with occasional resets.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      valid = ($urandom_range(0, 2) == 0);
      wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      a = $urandom;
      a[6:4] = 3'($urandom_range(0, 3));
      addr = a;
      case ($urandom_range(0, 7))
        0:       wdata = 32'hFFFF_FFFF;
        1:       wdata = $urandom;
        default: wdata = 32'($urandom_range(0, 5));
      endcase
    end
    @(negedge clk);
    reset = 1'b0; valid = 1'b0; wstrb = 4'h0;
    repeat (5) @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
